sram_8blk_ctrl: RTL and testbench
=================================

Name: sram_8blk_ctrl

Overview:
Initiator-side controller for the 8-block coefficient SRAM (sram_8blk). It accepts a valid/ready stream of 20-bit words and writes it linearly across all blocks, with block index in CADDR[10:8] and word address in CADDR[7:0]. It then switches to read mode and issues 8 parallel block reads per request, returning the eight Q words with a fixed-latency valid strobe. It sits between the FIR tap sequencer and sram_8blk.

Parameters:
DATA_W, 20, SRAM word width
ADDR_W, 8, per-block word address width (256 words/block)
BLKS, 8, number of SRAM blocks
BSEL_W, 3, block-select width (log2 BLKS); CADDR width = BSEL_W+ADDR_W
SRAM_LAT, 1, clock cycles from SRAM address capture to Q valid

Ports:
clk  in  1  system clock, posedge active
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a full load from CADDR 0
wr_valid  in  1  load word valid
wr_data  in  DATA_W  load word
wr_ready  out  1  controller accepts wr_data this cycle
load_done  out  1  high once all BLKS*2^ADDR_W words are written; cleared by start
rd_req  in  1  parallel read request (accepted only when rd_ready=1)
rd_addr  in  BLKS*ADDR_W  packed per-block addresses; block k at [k*ADDR_W +: ADDR_W]
rd_ready  out  1  high in READ state
rd_rvalid  out  1  single-cycle strobe: rd_data is valid
rd_data  out  BLKS*DATA_W  packed Q words; block k at [k*DATA_W +: DATA_W]
sram_cen  out  1  SRAM chip enable, active low
sram_wen  out  1  SRAM write enable, active low
sram_caddr  out  BSEL_W+ADDR_W  write address (block, word)
sram_d  out  DATA_W  write data
sram_a  out  BLKS*ADDR_W  packed read addresses to A0..A7
sram_q  in  BLKS*DATA_W  packed Q0..Q7 from SRAM

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous and active-low. All state is in posedge-clk flops with async clear.
- Reset values: state=IDLE, wr_ready=0, load_done=0, rd_ready=0, rd_rvalid=0, rd_data=0, sram_cen=1, sram_wen=1, sram_caddr=0, sram_d=0, sram_a=0, word counter=0.
- States: IDLE, LOAD, READ.
  - IDLE: start -> LOAD; counter=0.
  - LOAD: wr_ready=1. Each posedge with wr_valid&wr_ready is a write. Next cycle: sram_cen=0, sram_wen=0, sram_caddr=counter, sram_d=wr_data; counter++.
  - LOAD exit: when the accepted word has counter = BLKS*2^ADDR_W-1 (2047), go to READ. load_done rises in the same cycle as that last write's sram_cen=0. wr_ready drops in that cycle.
  - READ: rd_ready=1. start -> LOAD; clears load_done and counter. start in LOAD restarts from counter 0.
- Write-side idle cycles (wr_valid=0 in LOAD, or any non-write cycle): sram_cen=1, sram_wen=1; caddr/d hold their last values.
- Read pipeline. An rd_req accepted at edge N registers sram_a=rd_addr, sram_cen=0, sram_wen=1 for cycle N+1. The SRAM captures at edge N+1. sram_q is sampled SRAM_LAT cycles later into rd_data. rd_rvalid is high for exactly one cycle, SRAM_LAT+1 cycles after the accept edge (default 2).
- Back-to-back rd_req is allowed, one per cycle. The pipeline is fully overlapped; there is no stall.
- With no rd_req: sram_cen=1 and sram_a holds.
- rd_req while rd_ready=0: ignored, with no SRAM activity and no rd_rvalid.
- start asserted in READ with reads in flight: outstanding rd_rvalid strobes still complete with SRAM data. The first LOAD write occurs only after the pipeline drains (SRAM_LAT+1 cycles), so a read and a write are never issued in the same cycle.
- Reset mid-operation: everything returns to reset values immediately (async). In-flight reads/writes are dropped, and load_done=0.
- Counter width is BSEL_W+ADDR_W. It never wraps during LOAD because exit occurs at the terminal count.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs at reset values; sram_cen=1, sram_wen=1, rd_rvalid=0.
- Full load: start, then 2048 continuous words D=i -> sram_caddr steps 0..2047 (block 7 addr 255 last), sram_d=i one cycle after accept. load_done=1 with the last write; wr_ready=0 afterwards.
- Backpressure gaps: wr_valid toggled 1,0,0,1 -> sram_cen low only on the cycles after accepts; caddr strictly sequential, with no skipped or duplicated address.
- Parallel read: after load, rd_req with rd_addr = {7,6,...,0} per block -> sram_a matches next cycle. rd_rvalid exactly 2 cycles after the accept, with rd_data = sram_q. Repeat with 256 back-to-back requests and check every strobe.
- Illegal read: rd_req during LOAD -> no rd_rvalid and no extra sram_cen=0 cycle.
- Reset mid-load: rst_n=0 at word 1000 -> immediate reset values. A new start reloads from caddr 0 and load_done follows after 2048 writes.

Source files
------------

// File: rtl/sram_8blk_ctrl_if.sv
// Host-side bundle for sram_8blk_ctrl: start/done, the load stream and the parallel read port.
// Handshakes: a word moves on a posedge where wr_valid && wr_ready; a read is taken on a
// posedge where rd_req && rd_ready. Ready never depends combinationally on valid/req.
interface sram_8blk_ctrl_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 8,
    parameter int BLKS   = 8
) ();
    logic                     start;
    logic                     wr_valid;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_ready;
    logic                     load_done;
    logic                     rd_req;
    logic [BLKS*ADDR_W-1:0]   rd_addr;
    logic                     rd_ready;
    logic                     rd_rvalid;
    logic [BLKS*DATA_W-1:0]   rd_data;

    modport master (
        output start, wr_valid, wr_data, rd_req, rd_addr,
        input  wr_ready, load_done, rd_ready, rd_rvalid, rd_data
    );

    modport slave (
        input  start, wr_valid, wr_data, rd_req, rd_addr,
        output wr_ready, load_done, rd_ready, rd_rvalid, rd_data
    );
endinterface

// File: rtl/sram_8blk_ctrl.sv
// Initiator for the 8-block coefficient SRAM: linear load of every word, then overlapped
// 8-way parallel reads with a fixed SRAM_LAT+1 cycle strobe.
module sram_8blk_ctrl #(
    parameter int DATA_W   = 20,
    parameter int ADDR_W   = 8,
    parameter int BLKS     = 8,
    parameter int BSEL_W   = 3,
    parameter int SRAM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sram_8blk_ctrl_if.slave          host,
    output logic                     sram_cen,
    output logic                     sram_wen,
    output logic [BSEL_W+ADDR_W-1:0] sram_caddr,
    output logic [DATA_W-1:0]        sram_d,
    output logic [BLKS*ADDR_W-1:0]   sram_a,
    input  logic [BLKS*DATA_W-1:0]   sram_q,
    output logic [1:0]               state_dbg
);
    localparam int CNT_W = BSEL_W + ADDR_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLKS * (1 << ADDR_W) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [SRAM_LAT:0]   pipe;        // bit i set: a read was accepted i+1 edges ago
    logic [SRAM_LAT:0]   pipe_shift;
    logic                wr_fire;
    logic                rd_fire;

    assign state_dbg  = state;
    assign pipe_shift = pipe << 1;
    // start wins over a same-cycle write or read request
    assign wr_fire = (state == LOAD) && host.wr_valid && host.wr_ready && !host.start;
    assign rd_fire = (state == READ) && host.rd_req && host.rd_ready && !host.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            pipe           <= '0;
            host.wr_ready  <= 1'b0;
            host.load_done <= 1'b0;
            host.rd_ready  <= 1'b0;
            host.rd_rvalid <= 1'b0;
            host.rd_data   <= '0;
            sram_cen       <= 1'b1;
            sram_wen       <= 1'b1;
            sram_caddr     <= '0;
            sram_d         <= '0;
            sram_a         <= '0;
        end else begin
            sram_cen       <= 1'b1;
            sram_wen       <= 1'b1;
            pipe           <= pipe_shift | {{SRAM_LAT{1'b0}}, rd_fire};
            host.rd_rvalid <= pipe[SRAM_LAT];
            if (pipe[SRAM_LAT]) begin
                host.rd_data <= sram_q;
            end

            case (state)
                IDLE: begin
                    if (host.start) begin
                        state          <= LOAD;
                        cnt            <= '0;
                        host.load_done <= 1'b0;
                        host.wr_ready  <= (pipe_shift == '0);
                    end
                end
                LOAD: begin
                    if (host.start) begin
                        cnt            <= '0;
                        host.load_done <= 1'b0;
                        host.wr_ready  <= (pipe_shift == '0);
                    end else if (wr_fire) begin
                        sram_cen   <= 1'b0;
                        sram_wen   <= 1'b0;
                        sram_caddr <= cnt;
                        sram_d     <= host.wr_data;
                        if (cnt == LAST_WORD) begin
                            state          <= READ;
                            host.load_done <= 1'b1;
                            host.wr_ready  <= 1'b0;
                            host.rd_ready  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        // hold off the first write until in-flight reads have drained
                        host.wr_ready <= (pipe_shift == '0);
                    end
                end
                READ: begin
                    if (host.start) begin
                        state          <= LOAD;
                        cnt            <= '0;
                        host.load_done <= 1'b0;
                        host.rd_ready  <= 1'b0;
                        host.wr_ready  <= (pipe_shift == '0);
                    end else if (rd_fire) begin
                        sram_cen <= 1'b0;
                        sram_a   <= host.rd_addr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_8blk_ctrl.sv
// Directed bench for sram_8blk_ctrl: behavioural SRAM, transaction-level model and a
// per-cycle compare process, plus literal spot checks.
module tb_sram_8blk_ctrl;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 8;
  localparam int BLKS   = 8;
  localparam int BSEL_W = 3;
  localparam int CW     = BSEL_W + ADDR_W;
  localparam int NWORDS = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_8blk_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BLKS(BLKS)) host_if ();

  logic                   sram_cen;
  logic                   sram_wen;
  logic [CW-1:0]          sram_caddr;
  logic [DATA_W-1:0]      sram_d;
  logic [BLKS*ADDR_W-1:0] sram_a;
  logic [BLKS*DATA_W-1:0] sram_q = '0;
  logic [1:0]             state_dbg;

  sram_8blk_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BLKS(BLKS), .BSEL_W(BSEL_W), .SRAM_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (host_if),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_caddr (sram_caddr),
    .sram_d     (sram_d),
    .sram_a     (sram_a),
    .sram_q     (sram_q),
    .state_dbg  (state_dbg)
  );

  // Behavioural SRAM: 8 blocks x 256 words, Q registered one cycle after address capture
  logic [DATA_W-1:0] sram_mem [0:NWORDS-1];
  always @(posedge clk) begin
    if (!sram_cen && !sram_wen) sram_mem[sram_caddr] <= sram_d;
    if (!sram_cen && sram_wen) begin
      for (int k = 0; k < BLKS; k++)
        sram_q[k*DATA_W +: DATA_W] <= sram_mem[k*256 + int'(sram_a[k*ADDR_W +: ADDR_W])];
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 loading, 2 reading; expected outputs for the cycle after each edge
  int                      m_mode = 0;
  int                      m_n = 0;
  int                      m_cyc = 0;
  int                      last_acc = -100;
  logic                    e_wr_ready = 1'b0;
  logic                    e_load_done = 1'b0;
  logic                    e_rd_ready = 1'b0;
  logic                    e_rvalid = 1'b0;
  logic [BLKS*DATA_W-1:0]  e_rdata = '0;
  logic                    e_cen = 1'b1;
  logic                    e_wen = 1'b1;
  logic [CW-1:0]           e_caddr = '0;
  logic [DATA_W-1:0]       e_d = '0;
  logic [BLKS*ADDR_W-1:0]  e_a = '0;
  logic [DATA_W-1:0]       m_mem [0:NWORDS-1];
  int                      due_q[$];
  logic [BLKS*DATA_W-1:0]  exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_n = 0; m_cyc = 0; last_acc = -100;
      e_wr_ready = 1'b0; e_load_done = 1'b0; e_rd_ready = 1'b0;
      e_rvalid = 1'b0; e_rdata = '0; e_cen = 1'b1; e_wen = 1'b1;
      e_caddr = '0; e_d = '0; e_a = '0;
      due_q.delete(); exp_q.delete();
    end else begin
      m_cyc++;
      e_cen = 1'b1;
      e_wen = 1'b1;
      e_rvalid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == m_cyc) begin
        e_rvalid = 1'b1;
        e_rdata = exp_q.pop_front();
        void'(due_q.pop_front());
      end
      if (host_if.start) begin
        m_mode = 1; m_n = 0;
        e_load_done = 1'b0; e_rd_ready = 1'b0;
        e_wr_ready = (last_acc + 2 <= m_cyc);
      end else if (m_mode == 1) begin
        if (host_if.wr_valid && e_wr_ready) begin
          e_cen = 1'b0; e_wen = 1'b0;
          e_caddr = CW'(m_n);
          e_d = host_if.wr_data;
          m_mem[m_n] = host_if.wr_data;
          m_n++;
          if (m_n == NWORDS) begin
            m_mode = 2; e_load_done = 1'b1; e_wr_ready = 1'b0; e_rd_ready = 1'b1;
          end
        end else begin
          e_wr_ready = (last_acc + 2 <= m_cyc);
        end
      end else if (m_mode == 2 && host_if.rd_req) begin
        logic [BLKS*DATA_W-1:0] ex;
        e_cen = 1'b0;
        e_a = host_if.rd_addr;
        last_acc = m_cyc;
        for (int k = 0; k < BLKS; k++)
          ex[k*DATA_W +: DATA_W] = m_mem[k*256 + int'(host_if.rd_addr[k*ADDR_W +: ADDR_W])];
        exp_q.push_back(ex);
        due_q.push_back(m_cyc + 2);
      end
    end
  end

  always @(negedge clk) begin
    chk("wr_ready", host_if.wr_ready, e_wr_ready);
    chk("load_done", host_if.load_done, e_load_done);
    chk("rd_ready", host_if.rd_ready, e_rd_ready);
    chk("rd_rvalid", host_if.rd_rvalid, e_rvalid);
    chk("sram_cen", sram_cen, e_cen);
    chk("sram_wen", sram_wen, e_wen);
    chk("sram_caddr", sram_caddr, e_caddr);
    chk("sram_d", sram_d, e_d);
    chk("sram_a", sram_a, e_a);
    if (e_rvalid) chk("rd_data", host_if.rd_data, e_rdata);
    if (!rst_n) chk("rd_data_reset", host_if.rd_data, '0);
  end

  function automatic logic [DATA_W-1:0] word_val(input int i, input int salt);
    if (salt == 0) return DATA_W'(i);
    return DATA_W'(i * 7 + 3) ^ 20'h5a5a5;
  endfunction

  function automatic logic [BLKS*ADDR_W-1:0] rd_pat(input int p, input int j);
    logic [BLKS*ADDR_W-1:0] v;
    for (int k = 0; k < BLKS; k++) begin
      if (p == 0)      v[k*ADDR_W +: ADDR_W] = ADDR_W'(k);
      else if (p == 1) v[k*ADDR_W +: ADDR_W] = ADDR_W'(j + k * 31);
      else             v[k*ADDR_W +: ADDR_W] = ADDR_W'(j * 13 + k * 5 + 200);
    end
    return v;
  endfunction

  task automatic clear_inputs();
    host_if.start = 1'b0;
    host_if.wr_valid = 1'b0;
    host_if.wr_data = '0;
    host_if.rd_req = 1'b0;
    host_if.rd_addr = '0;
  endtask

  task automatic do_start();
    @(negedge clk);
    host_if.start = 1'b1;
    @(negedge clk);
    host_if.start = 1'b0;
  endtask

  // Pushes target words; gaps=1 uses a 1,0,0,1 valid pattern early and pokes rd_req mid-load
  task automatic load_words(input int target, input int gaps, input int salt);
    int idx = 0;
    int guard = 0;
    int ph = 0;
    logic rdy;
    logic vld;
    while (idx < target && guard < 6000) begin
      @(negedge clk);
      guard++;
      rdy = host_if.wr_ready;
      vld = 1'b1;
      if (gaps == 1 && idx < 40) begin
        vld = (ph % 4 == 0) || (ph % 4 == 3);
        ph++;
      end
      host_if.wr_valid = vld;
      host_if.wr_data = vld ? word_val(idx, salt) : DATA_W'($urandom_range(0, 20'hfffff));
      host_if.rd_req = (gaps == 1 && idx >= 100 && idx < 110);
      host_if.rd_addr = {$urandom, $urandom};
      @(posedge clk);
      if (vld && rdy) idx++;
    end
    @(negedge clk);
    host_if.wr_valid = 1'b0;
    host_if.rd_req = 1'b0;
    chk("load_word_count", idx, target);
  endtask

  task automatic read_burst(input int n, input int p);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      host_if.rd_req = 1'b1;
      host_if.rd_addr = rd_pat(p, j);
    end
    @(negedge clk);
    host_if.rd_req = 1'b0;
  endtask

  initial begin
    clear_inputs();
    repeat (6) begin
      @(negedge clk);
      host_if.start = 1'($urandom_range(0, 1));
      host_if.wr_valid = 1'($urandom_range(0, 1));
      host_if.wr_data = DATA_W'($urandom_range(0, 20'hfffff));
      host_if.rd_req = 1'($urandom_range(0, 1));
      host_if.rd_addr = {$urandom, $urandom};
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_wr_ready", host_if.wr_ready, 1'b0);
    chk("idle_rd_ready", host_if.rd_ready, 1'b0);
    host_if.rd_req = 1'b1;
    host_if.rd_addr = 64'h0102030405060708;
    @(negedge clk);
    host_if.rd_req = 1'b0;
    chk("idle_read_cen", sram_cen, 1'b1);

    // Load 1: D=i with early backpressure gaps and illegal reads
    do_start();
    load_words(NWORDS, 1, 0);
    chk("last_caddr", sram_caddr, 11'h7ff);
    chk("last_d", sram_d, 20'd2047);
    chk("last_cen", sram_cen, 1'b0);
    chk("last_load_done", host_if.load_done, 1'b1);
    chk("last_wr_ready", host_if.wr_ready, 1'b0);

    // Single parallel read, block k at address k -> word k*256+k
    host_if.rd_req = 1'b1;
    host_if.rd_addr = rd_pat(0, 0);
    @(negedge clk);
    host_if.rd_req = 1'b0;
    chk("rd_issue_a", sram_a, 64'h0706050403020100);
    chk("rd_issue_cen", sram_cen, 1'b0);
    chk("rd_issue_wen", sram_wen, 1'b1);
    @(negedge clk);
    chk("rd_rvalid_early", host_if.rd_rvalid, 1'b0);
    @(negedge clk);
    chk("rd_rvalid_lat2", host_if.rd_rvalid, 1'b1);
    chk("rd_data_lit", host_if.rd_data,
        {20'h00707, 20'h00606, 20'h00505, 20'h00404, 20'h00303, 20'h00202, 20'h00101, 20'h00000});
    @(negedge clk);
    chk("rd_rvalid_single", host_if.rd_rvalid, 1'b0);

    read_burst(256, 1);
    repeat (4) @(negedge clk);

    // Start while reads are in flight
    for (int j = 0; j < 3; j++) begin
      host_if.rd_req = 1'b1;
      host_if.rd_addr = rd_pat(2, j);
      @(negedge clk);
    end
    host_if.rd_req = 1'b0;
    host_if.start = 1'b1;
    @(negedge clk);
    host_if.start = 1'b0;
    chk("drain_wr_ready", host_if.wr_ready, 1'b0);
    chk("restart_load_done", host_if.load_done, 1'b0);
    chk("restart_rd_ready", host_if.rd_ready, 1'b0);

    // Load 2 aborted by reset at word 1000
    load_words(1000, 0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cen", sram_cen, 1'b1);
    chk("arst_wen", sram_wen, 1'b1);
    chk("arst_caddr", sram_caddr, 11'h000);
    chk("arst_d", sram_d, 20'h00000);
    chk("arst_wr_ready", host_if.wr_ready, 1'b0);
    chk("arst_load_done", host_if.load_done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Load 3 from scratch, then a short read burst
    do_start();
    load_words(NWORDS, 0, 1);
    chk("reload_caddr", sram_caddr, 11'h7ff);
    chk("reload_load_done", host_if.load_done, 1'b1);
    read_burst(16, 2);
    repeat (5) @(negedge clk);
    chk("pending_reads", due_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
